// File: rtl/rgmii_tsu_if.sv
// rtl/rgmii_tsu_if.sv - RGMII tap, RTC and timestamp FIFO read signals for rgmii_tsu
interface rgmii_tsu_if;
  logic         rgmii_ctrl;
  logic [3:0]   rgmii_data;
  logic         giga_mode;
  logic [7:0]   ptp_msgid_mask;
  logic [79:0]  rtc_timer_in;
  logic         q_rd_en;
  logic [7:0]   q_rd_stat;
  logic [127:0] q_rd_data;

  modport master (
    output rgmii_ctrl, rgmii_data, giga_mode, ptp_msgid_mask, rtc_timer_in, q_rd_en,
    input  q_rd_stat, q_rd_data
  );

  modport slave (
    input  rgmii_ctrl, rgmii_data, giga_mode, ptp_msgid_mask, rtc_timer_in, q_rd_en,
    output q_rd_stat, q_rd_data
  );
endinterface

// File: rtl/rgmii_tsu.sv
// rtl/rgmii_tsu.sv - PTP event timestamp unit on one RGMII direction
// Bytes are realigned with the RTC sample taken at their sampling edge, parsed, and queued at frame end.
module rgmii_tsu #(
  parameter int Q_DEPTH = 16
) (
  input logic        rgmii_clk,
  input logic        rst,
  rgmii_tsu_if.slave bus
);
  localparam int AW = $clog2(Q_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ETH, S_IP, S_PTP, S_WAIT} state_t;

  logic [3:0]  lo_r, hi_n;
  logic        ctrl_r, phase, b_vld, f_ctrl, f_prev;
  logic [7:0]  b_dat;
  logic [79:0] ts_r, b_ts;

  always_ff @(negedge rgmii_clk or posedge rst) begin
    if (rst) hi_n <= '0;
    else     hi_n <= bus.rgmii_data;
  end

  // DDR bytes are emitted one cycle later than SDR bytes, so ctrl and RTC are delayed to match
  always_ff @(posedge rgmii_clk or posedge rst) begin
    if (rst) begin
      lo_r   <= '0;
      ctrl_r <= 1'b0;
      phase  <= 1'b0;
      ts_r   <= '0;
      b_vld  <= 1'b0;
      b_dat  <= '0;
      b_ts   <= '0;
      f_ctrl <= 1'b0;
    end else begin
      ctrl_r <= bus.rgmii_ctrl;
      ts_r   <= bus.rtc_timer_in;
      phase  <= bus.rgmii_ctrl && !bus.giga_mode && !phase;
      if (bus.giga_mode || !phase) lo_r <= bus.rgmii_data;
      if (bus.giga_mode) begin
        b_vld  <= ctrl_r;
        b_dat  <= {hi_n, lo_r};
        b_ts   <= ts_r;
        f_ctrl <= ctrl_r;
      end else begin
        b_vld  <= bus.rgmii_ctrl && phase;
        b_dat  <= {bus.rgmii_data, lo_r};
        b_ts   <= bus.rtc_timer_in;
        f_ctrl <= bus.rgmii_ctrl;
      end
    end
  end

  state_t       state;
  logic [7:0]   k, et_hi, pbase, et_pos, l3, rel;
  logic         vlan, ts_ack, seq_ok, q_wr_en, eof, is_event;
  logic [3:0]   msg;
  logic [15:0]  seq;
  logic [79:0]  ts_reg;
  logic [127:0] q_wr_data;

  assign et_pos   = vlan ? 8'd16 : 8'd12;
  assign l3       = et_pos + 8'd2;
  assign rel      = k - l3;
  assign eof      = f_prev && !f_ctrl;
  assign is_event = !msg[3] && bus.ptp_msgid_mask[msg[2:0]];

  always_ff @(posedge rgmii_clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      k         <= '0;
      et_hi     <= '0;
      pbase     <= '0;
      vlan      <= 1'b0;
      ts_ack    <= 1'b0;
      seq_ok    <= 1'b0;
      q_wr_en   <= 1'b0;
      msg       <= '0;
      seq       <= '0;
      ts_reg    <= '0;
      q_wr_data <= '0;
      f_prev    <= 1'b0;
    end else begin
      q_wr_en <= 1'b0;
      f_prev  <= f_ctrl;
      if (eof) begin
        if (state != S_IDLE && ts_ack && seq_ok && is_event) begin
          q_wr_en   <= 1'b1;
          q_wr_data <= {ts_reg, seq, msg, 28'h0};
        end
        ts_ack <= 1'b0;
        state  <= S_IDLE;
      end else if (b_vld) begin
        case (state)
          S_IDLE: if (b_dat == 8'hD5) begin
            ts_reg <= b_ts;
            ts_ack <= 1'b1;
            k      <= '0;
            vlan   <= 1'b0;
            seq_ok <= 1'b0;
            state  <= S_ETH;
          end
          S_ETH: begin
            k <= k + 8'd1;
            if (k == et_pos) et_hi <= b_dat;
            else if (k == et_pos + 8'd1) begin
              if ({et_hi, b_dat} == 16'h8100 && !vlan) vlan <= 1'b1;
              else if ({et_hi, b_dat} == 16'h88F7) begin
                pbase <= k + 8'd1;
                state <= S_PTP;
              end else if ({et_hi, b_dat} == 16'h0800) state <= S_IP;
              else state <= S_WAIT;
            end
          end
          S_IP: begin
            k <= k + 8'd1;
            if ((rel == 8'd0 && b_dat[3:0] != 4'd5) || (rel == 8'd9 && b_dat != 8'd17) ||
                (rel == 8'd22 && b_dat != 8'h01))
              state <= S_WAIT;
            else if (rel == 8'd23) begin
              if (b_dat == 8'h3F) begin
                pbase <= k + 8'd5;
                state <= S_PTP;
              end else state <= S_WAIT;
            end
          end
          S_PTP: begin
            k <= k + 8'd1;
            if (k == pbase) msg <= b_dat[3:0];
            if (k == pbase + 8'd30) seq[15:8] <= b_dat;
            if (k == pbase + 8'd31) begin
              seq[7:0] <= b_dat;
              seq_ok   <= 1'b1;
              state    <= S_WAIT;
            end
          end
          default: ;
        endcase
      end
    end
  end

  logic [127:0]  mem [Q_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    count;
  logic          push, pop;

  // A full queue drops the new entry even if a pop happens in the same cycle
  assign push = q_wr_en && (count != 8'(Q_DEPTH));
  assign pop  = bus.q_rd_en && (count != 8'd0);

  always_ff @(posedge rgmii_clk) begin
    if (push) mem[wr_ptr] <= q_wr_data;
  end

  always_ff @(posedge rgmii_clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {7'd0, push} - {7'd0, pop};
    end
  end

  assign bus.q_rd_stat = count;
  assign bus.q_rd_data = (count == 8'd0) ? '0 : mem[rd_ptr];
endmodule

// File: tb/tb_rgmii_tsu.sv
// tb/tb_rgmii_tsu.sv - directed bench for rgmii_tsu
module tb_rgmii_tsu;
  logic clk = 1'b0;
  logic rst;
  rgmii_tsu_if bus();

  rgmii_tsu #(.Q_DEPTH(16)) dut (.rgmii_clk(clk), .rst(rst), .bus(bus));

  always #4 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          pulses = 0;
  logic [7:0]  fr[$];
  logic [79:0] rtc = 80'h00AB_CDEF_0000_0000_1000;
  logic [79:0] exp_ts;

  assign bus.rtc_timer_in = rtc;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1;
    rtc = rtc + 80'd1;
  end

  initial forever begin
    @(negedge clk);
    if (dut.q_wr_en === 1'b1) pulses++;
  end

  task automatic put(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) fr.push_back(b);
  endtask

  task automatic build(input bit vlan, input bit ip, input logic [15:0] dport,
                       input logic [3:0] msg, input logic [15:0] seq);
    fr.delete();
    put(8'h55, 7); put(8'hD5, 1);
    put(8'h01, 1); put(8'h1B, 1); put(8'h19, 1); put(8'h00, 3);
    put(8'h02, 6);
    if (vlan) begin put(8'h81, 1); put(8'h00, 2); put(8'h05, 1); end
    if (ip) begin
      put(8'h08, 1); put(8'h00, 1);
      put(8'h45, 1); put(8'h00, 8); put(8'h11, 1); put(8'h00, 10);
      put(8'h01, 1); put(8'h3F, 1); put(dport[15:8], 1); put(dport[7:0], 1);
      put(8'h00, 1); put(8'h44, 1); put(8'h00, 2);
    end else begin
      put(8'h88, 1); put(8'hF7, 1);
    end
    put({4'h0, msg}, 1); put(8'h02, 1); put(8'h00, 28);
    put(seq[15:8], 1); put(seq[7:0], 1); put(8'h00, 2);
    put(8'hAA, 10);
    put(8'hDE, 1); put(8'hAD, 1); put(8'hBE, 1); put(8'hEF, 1);
  endtask

  // Index 7 is the SFD: exp_ts is the RTC value seen at the edge sampling its last nibble of the cycle
  task automatic send(input bit giga, input int nb, input bit drop);
    bus.giga_mode = giga;
    for (int i = 0; i < nb; i++) begin
      if (giga) begin
        @(negedge clk); #2;
        bus.rgmii_data = fr[i][3:0];
        bus.rgmii_ctrl = 1'b1;
        if (i == 7) exp_ts = rtc;
        @(posedge clk); #2;
        bus.rgmii_data = fr[i][7:4];
      end else begin
        @(negedge clk);
        bus.rgmii_data = fr[i][3:0];
        bus.rgmii_ctrl = 1'b1;
        @(negedge clk);
        bus.rgmii_data = fr[i][7:4];
        if (i == 7) exp_ts = rtc;
      end
    end
    if (drop) begin
      @(negedge clk);
      if (giga) #2;
      bus.rgmii_ctrl = 1'b0;
      repeat (12) @(negedge clk);
    end
  endtask

  task automatic pop();
    @(negedge clk); bus.q_rd_en = 1'b1;
    @(negedge clk); bus.q_rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.rgmii_ctrl = 1'b0;
    bus.rgmii_data = 4'h0;
    bus.giga_mode = 1'b0;
    bus.ptp_msgid_mask = 8'hFF;
    bus.q_rd_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_stat", bus.q_rd_stat, 0);
    check("rst_data", bus.q_rd_data, 0);
    check("rst_wr_en", dut.q_wr_en, 0);
    rst = 1'b0;
    @(negedge clk);

    build(0, 0, 16'h0, 4'd0, 16'h1234);
    pulses = 0;
    send(0, fr.size(), 1);
    check("sdr_pulses", pulses, 1);
    check("sdr_stat", bus.q_rd_stat, 1);
    check("sdr_seq_msg", bus.q_rd_data[47:28], 20'h12340);
    check("sdr_ts", bus.q_rd_data[127:48], exp_ts);
    check("sdr_pad", bus.q_rd_data[27:0], 0);
    pop();
    check("sdr_pop_stat", bus.q_rd_stat, 0);
    check("sdr_pop_data", bus.q_rd_data, 0);

    bus.ptp_msgid_mask = 8'hFE;
    pulses = 0;
    send(0, fr.size(), 1);
    check("mask_pulses", pulses, 0);
    check("mask_stat", bus.q_rd_stat, 0);
    bus.ptp_msgid_mask = 8'hFF;

    build(1, 1, 16'd319, 4'd1, 16'd7);
    send(1, fr.size(), 1);
    check("ddr_stat", bus.q_rd_stat, 1);
    check("ddr_msg", bus.q_rd_data[31:28], 1);
    check("ddr_seq", bus.q_rd_data[47:32], 7);
    check("ddr_ts", bus.q_rd_data[127:48], exp_ts);
    pop();
    check("ddr_pop_stat", bus.q_rd_stat, 0);

    build(1, 1, 16'd320, 4'd0, 16'd9);
    send(1, fr.size(), 1);
    check("udp320_stat", bus.q_rd_stat, 0);
    build(0, 0, 16'h0, 4'd8, 16'd5);
    send(1, fr.size(), 1);
    check("followup_stat", bus.q_rd_stat, 0);
    build(0, 0, 16'h0, 4'd0, 16'h0055);
    send(1, 53, 1);
    check("trunc_stat", bus.q_rd_stat, 0);
    pop();
    check("empty_pop_stat", bus.q_rd_stat, 0);

    for (int i = 0; i < 17; i++) begin
      build(0, 0, 16'h0, 4'd0, 16'h0100 + 16'(i));
      send(1, fr.size(), 1);
    end
    check("full_stat", bus.q_rd_stat, 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_seq%0d", i), bus.q_rd_data[47:32], 16'h0100 + 16'(i));
      pop();
    end
    check("drain_stat", bus.q_rd_stat, 0);

    build(0, 0, 16'h0, 4'd0, 16'h0AAA);
    send(1, fr.size(), 1);
    check("pre_rst_stat", bus.q_rd_stat, 1);
    build(0, 0, 16'h0, 4'd0, 16'h0BBB);
    pulses = 0;
    send(1, 40, 0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_stat", bus.q_rd_stat, 0);
    check("midrst_data", bus.q_rd_data, 0);
    bus.rgmii_ctrl = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_pulses", pulses, 0);
    build(0, 0, 16'h0, 4'd0, 16'h0CCC);
    send(1, fr.size(), 1);
    check("post_rst_stat", bus.q_rd_stat, 1);
    check("post_rst_seq", bus.q_rd_data[47:32], 16'h0CCC);
    check("post_rst_ts", bus.q_rd_data[127:48], exp_ts);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
